// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory req/ack bus between ifetch and instruction memory
// master = fetch unit (drives request and address), slave = memory (drives ack and data)
interface ifetch_if;
  logic        imem_req_out;
  logic [15:0] imem_addr_out;
  logic        imem_ack_in;
  logic [15:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_rdata_in
  );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: owns the PC, fetches words over req/ack, strobes the IR
// Optional fetch timeout fault enabled by defining IFETCH_TIMEOUT_EN.
module ifetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_in,
  input  logic        branch_in,
  input  logic [15:0] ia_in,
  ifetch_if.master    imem,
  output logic [15:0] ins_out,
  output logic        il_out,
  output logic [15:0] pc_out,
  output logic        busy_out,
  output logic        fault_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] ins_q;
  logic        il_q;
  logic        req_q;
  logic [15:0] addr_q;
  logic        busy_q;

  logic [15:0] pc_br_d;
  logic [15:0] pc_inc_d;
  logic [15:0] pc_sel_d;

  // Two's-complement add modulo 2^16 is the same as an unsigned add.
  always_comb begin
    pc_br_d  = pc_q + ia_in;
    pc_inc_d = pc_q + 16'd1;
    pc_sel_d = branch_in ? pc_br_d : pc_q;
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = TIMEOUT_CYC[7:0];
  logic [7:0] cnt_q;
  logic       fault_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ins_q   <= 16'h0000;
      il_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= 16'h0000;
      busy_q  <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
`endif
    end else begin
      il_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (branch_in) begin
            pc_q <= pc_br_d;
          end
          // A same-cycle branch redirects this fetch to the branched PC.
          if (fetch_in) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_sel_d;
            busy_q  <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        S_REQ: begin
          if (imem.imem_ack_in) begin
            ins_q   <= imem.imem_rdata_in;
            pc_q    <= pc_inc_d;
            req_q   <= 1'b0;
            il_q    <= 1'b1;
            state_q <= S_LOAD;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (cnt_q + 8'd1 == TO_LIM) begin
            cnt_q   <= cnt_q + 8'd1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        S_LOAD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req_out  = req_q;
  assign imem.imem_addr_out = addr_q;
  assign ins_out            = ins_q;
  assign il_out             = il_q;
  assign pc_out             = pc_q;
  assign busy_out           = busy_q;
`ifdef IFETCH_TIMEOUT_EN
  assign fault_out          = fault_q;
`else
  assign fault_out          = 1'b0;
`endif

endmodule
